// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the writeback scheduler.
package regfile_pkg;

    localparam int NUM_REG        = 32;
    localparam int REG_IDX_W      = 5;
    localparam int DEFAULT_DATA_W = 64;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for long-latency destinations plus the outstanding-op counter
// and the hazard/full compare used by the issue stall.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     set_valid,
    input  reg_idx_t set_rd,
    input  logic     clr_valid,
    input  reg_idx_t clr_rd,
    input  logic     chk_long,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    input  reg_idx_t rd,
    output logic     hazard,
    output logic     full
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [NUM_REG-1:1] busy_q;
    logic [NUM_REG-1:0] busy;
    logic [NUM_REG-1:0] clr_mask;
    logic [NUM_REG-1:0] live;
    logic [CNT_W-1:0]   out_cnt;

    // x0 can never be busy, so it is hard-wired to zero here.
    assign busy     = {busy_q, 1'b0};
    assign clr_mask = NUM_REG'(clr_valid) << clr_rd;
    // The register being drained this cycle is bypassed by the register file.
    assign live     = busy & ~clr_mask;

    assign hazard = live[rs1] | live[rs2] | live[rd];
    assign full   = chk_long & (out_cnt == CNT_W'(MAX_OUT)) & ~clr_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            for (int r = 1; r < NUM_REG; r++) begin
                if (set_valid && (set_rd == REG_IDX_W'(r))) begin
                    busy_q[r] <= 1'b1;
                end else if (clr_valid && (clr_rd == REG_IDX_W'(r))) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    // A stray return with nothing outstanding leaves the count at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_cnt <= '0;
        end else begin
            case ({set_valid, clr_valid})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   if (out_cnt != '0) out_cnt <= out_cnt - CNT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Merges in-order pipeline writeback and buffered long-latency results onto the
// single register-file write port; pipeline WB always wins the port.
module regfile_wb_sched
    import regfile_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_issue_valid,
    input  logic              i_issue_long,
    input  logic [4:0]        i_issue_rd,
    input  logic [4:0]        i_issue_rs1,
    input  logic [4:0]        i_issue_rs2,
    output logic              o_issue_stall,
    input  logic              i_wb_valid,
    input  logic [4:0]        i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_lu_valid,
    input  logic [4:0]        i_lu_rd,
    input  logic [DATA_W-1:0] i_lu_data,
    output logic              o_lu_ready,
    output logic              o_RegWrite,
    output logic [4:0]        o_WriteReg,
    output logic [DATA_W-1:0] o_WriteData
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic                hold_valid;
    reg_idx_t            hold_rd;
    logic [DATA_W-1:0]   hold_data;
    logic [STARVE_W-1:0] starve_cnt;

    logic drain;
    logic lu_fire;
    logic issue_fire;
    logic starve;
    logic hazard;
    logic full;

    assign drain      = hold_valid & ~i_wb_valid;
    assign lu_fire    = i_lu_valid & o_lu_ready;
    assign issue_fire = i_issue_valid & i_issue_long & ~o_issue_stall;
    assign starve     = (starve_cnt == STARVE_W'(STARVE_MAX));

    assign o_lu_ready    = i_rst_n & ~hold_valid;
    assign o_issue_stall = ~i_rst_n | (i_issue_valid & (hazard | full | starve));

    regfile_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_scoreboard (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .set_valid (issue_fire),
        .set_rd    (i_issue_rd),
        .clr_valid (drain),
        .clr_rd    (hold_rd),
        .chk_long  (i_issue_long),
        .rs1       (i_issue_rs1),
        .rs2       (i_issue_rs2),
        .rd        (i_issue_rd),
        .hazard    (hazard),
        .full      (full)
    );

    // Writes to x0 are suppressed because the register file forwards write data.
    always_comb begin
        o_RegWrite  = 1'b0;
        o_WriteReg  = '0;
        o_WriteData = '0;
        if (i_rst_n) begin
            if (i_wb_valid) begin
                o_RegWrite  = (i_wb_rd != '0);
                o_WriteReg  = i_wb_rd;
                o_WriteData = i_wb_data;
            end else if (hold_valid) begin
                o_RegWrite  = (hold_rd != '0);
                o_WriteReg  = hold_rd;
                o_WriteData = hold_data;
            end
        end
    end

    // Capture and drain never coincide: ready is only offered while empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_data  <= '0;
        end else if (lu_fire) begin
            hold_valid <= 1'b1;
            hold_rd    <= i_lu_rd;
            hold_data  <= i_lu_data;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if (!hold_valid || drain) begin
            starve_cnt <= '0;
        end else if (!starve) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Table-driven bench for regfile_wb_sched: per-cycle stall/ready vectors plus a
// write-port scoreboard fed by a small model of the hold register.
module tb_regfile_wb_sched;

    localparam int DATA_W = 64;
    localparam int EXP_W  = 5 + DATA_W;

    logic              clk;
    logic              rst_n;
    logic              issue_valid;
    logic              issue_long;
    logic [4:0]        issue_rd;
    logic [4:0]        issue_rs1;
    logic [4:0]        issue_rs2;
    logic              issue_stall;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              lu_valid;
    logic [4:0]        lu_rd;
    logic [DATA_W-1:0] lu_data;
    logic              lu_ready;
    logic              reg_write;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] write_data;

    regfile_wb_sched #(
        .DATA_W     (DATA_W),
        .MAX_OUT    (4),
        .STARVE_MAX (8)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_issue_valid (issue_valid),
        .i_issue_long  (issue_long),
        .i_issue_rd    (issue_rd),
        .i_issue_rs1   (issue_rs1),
        .i_issue_rs2   (issue_rs2),
        .o_issue_stall (issue_stall),
        .i_wb_valid    (wb_valid),
        .i_wb_rd       (wb_rd),
        .i_wb_data     (wb_data),
        .i_lu_valid    (lu_valid),
        .i_lu_rd       (lu_rd),
        .i_lu_data     (lu_data),
        .o_lu_ready    (lu_ready),
        .o_RegWrite    (reg_write),
        .o_WriteReg    (write_reg),
        .o_WriteData   (write_data)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic              iv;
        logic              il;
        logic [4:0]        ird;
        logic [4:0]        irs1;
        logic [4:0]        irs2;
        logic              wv;
        logic [4:0]        wrd;
        logic [DATA_W-1:0] wd;
        logic              lv;
        logic [4:0]        lrd;
        logic [DATA_W-1:0] ld;
        logic              es;
        logic              er;
    } vec_t;

    vec_t vecs[$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [EXP_W-1:0] exp_q[$];

    logic              m_hv;
    logic [4:0]        m_hrd;
    logic [DATA_W-1:0] m_hd;

    function automatic vec_t mk(logic iv, logic il, logic [4:0] ird, logic [4:0] irs1,
                                logic [4:0] irs2, logic es, logic er);
        vec_t v;
        v.iv = iv; v.il = il; v.ird = ird; v.irs1 = irs1; v.irs2 = irs2;
        v.wv = 1'b0; v.wrd = '0; v.wd = '0;
        v.lv = 1'b0; v.lrd = '0; v.ld = '0;
        v.es = es; v.er = er;
        return v;
    endfunction

    function automatic vec_t with_wb(vec_t v, logic [4:0] rd, logic [DATA_W-1:0] d);
        vec_t r = v;
        r.wv = 1'b1; r.wrd = rd; r.wd = d;
        return r;
    endfunction

    function automatic vec_t with_lu(vec_t v, logic [4:0] rd, logic [DATA_W-1:0] d);
        vec_t r = v;
        r.lv = 1'b1; r.lrd = rd; r.ld = d;
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-port scoreboard: every DUT write must match the oldest expected one.
    always @(negedge clk) begin
        if (reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL write_port: unexpected write x%0d=0x%0h, none expected",
                         write_reg, write_data);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                check("write_rd", {{(DATA_W-5){1'b0}}, write_reg}, {{(DATA_W-5){1'b0}}, e[EXP_W-1:DATA_W]});
                check("write_data", write_data, e[DATA_W-1:0]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input vec_t v, input int idx);
        logic old_hv;
        issue_valid = v.iv; issue_long = v.il; issue_rd = v.ird;
        issue_rs1 = v.irs1; issue_rs2 = v.irs2;
        wb_valid = v.wv; wb_rd = v.wrd; wb_data = v.wd;
        lu_valid = v.lv; lu_rd = v.lrd; lu_data = v.ld;
        #1;
        check($sformatf("vec%0d stall", idx), {63'd0, issue_stall}, {63'd0, v.es});
        check($sformatf("vec%0d lu_ready", idx), {63'd0, lu_ready}, {63'd0, v.er});
        if (v.wv) begin
            if (v.wrd != 5'd0) exp_q.push_back({v.wrd, v.wd});
        end else if (m_hv && m_hrd != 5'd0) begin
            exp_q.push_back({m_hrd, m_hd});
        end
        old_hv = m_hv;
        if (!v.wv) m_hv = 1'b0;
        if (v.lv && !old_hv) begin
            m_hv = 1'b1; m_hrd = v.lrd; m_hd = v.ld;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_long = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        wb_valid = 0; wb_rd = 0; wb_data = '0;
        lu_valid = 0; lu_rd = 0; lu_data = '0;
    endtask

    // ---------------- test ----------------
    initial begin
        m_hv = 1'b0; m_hrd = '0; m_hd = '0;
        rst_n = 1'b0;
        idle_inputs();

        // x0 handling: WB to x0, long issue to x0, read of x0, drain of x0
        vecs.push_back(with_wb(mk(0, 0, 0, 0, 0, 0, 1), 5'd0, 64'hFF));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(with_lu(mk(0, 0, 0, 0, 0, 0, 1), 5'd0, 64'h55));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        // RAW on x5 until the hold drains 0x1234; stall drops in the drain cycle
        vecs.push_back(mk(1, 1, 5, 1, 2, 0, 1));
        vecs.push_back(mk(1, 0, 8, 5, 0, 1, 1));
        vecs.push_back(with_lu(mk(1, 0, 8, 5, 0, 1, 1), 5'd5, 64'h1234));
        vecs.push_back(mk(1, 0, 8, 5, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8, 5, 0, 0, 1));
        // WB x6 beats pending hold x7; x7 lands on the next idle cycle
        vecs.push_back(mk(1, 1, 7, 0, 0, 0, 1));
        vecs.push_back(with_lu(mk(0, 0, 0, 0, 0, 0, 1), 5'd7, 64'hBB));
        vecs.push_back(with_wb(mk(1, 0, 3, 7, 0, 1, 0), 5'd6, 64'hAA));
        vecs.push_back(mk(1, 0, 3, 7, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        // four outstanding, fifth stalls, same-cycle drain releases it
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 1, 5'(10 + i), 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 14, 0, 0, 1, 1));
        vecs.push_back(with_lu(mk(1, 1, 14, 0, 0, 1, 1), 5'd10, 64'h10));
        vecs.push_back(mk(1, 1, 14, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 15, 10, 0, 1, 1));
        for (int i = 11; i <= 14; i++) begin
            vecs.push_back(with_lu(mk(0, 0, 0, 0, 0, 0, 1), 5'(i), 64'(256 + i)));
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        end
        vecs.push_back(mk(1, 0, 1, 11, 14, 0, 1));
        // starvation: 8 blocked cycles, then forced stall until the drain clears it
        vecs.push_back(mk(1, 1, 20, 0, 0, 0, 1));
        vecs.push_back(with_lu(mk(0, 0, 0, 0, 0, 0, 1), 5'd20, 64'h2020));
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(with_wb(mk(1, 0, 2, 1, 0, (i >= 8), 0), 5'(1 + i),
                                   {$urandom, $urandom}));
        end
        vecs.push_back(mk(1, 0, 2, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 2, 20, 0, 0, 1));

        // reset state
        #1;
        check("rst stall", {63'd0, issue_stall}, 64'd1);
        check("rst lu_ready", {63'd0, lu_ready}, 64'd0);
        check("rst regwrite", {63'd0, reg_write}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // reset asserted while the hold register is full
        step(mk(1, 1, 9, 0, 0, 0, 1), 1000);
        step(with_lu(mk(0, 0, 0, 0, 0, 0, 1), 5'd9, 64'h99), 1001);
        rst_n = 1'b0;
        issue_valid = 1; issue_rs1 = 5'd9;
        wb_valid = 1; wb_rd = 5'd3; wb_data = 64'h33;
        m_hv = 1'b0;
        #1;
        check("midrst regwrite", {63'd0, reg_write}, 64'd0);
        check("midrst writereg", {59'd0, write_reg}, 64'd0);
        check("midrst writedata", write_data, 64'd0);
        check("midrst lu_ready", {63'd0, lu_ready}, 64'd0);
        check("midrst stall", {63'd0, issue_stall}, 64'd1);
        @(posedge clk);
        #1;
        check("midrst2 stall", {63'd0, issue_stall}, 64'd1);
        check("midrst2 lu_ready", {63'd0, lu_ready}, 64'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(mk(1, 0, 1, 9, 0, 0, 1), 1002);
        step(mk(0, 0, 0, 0, 0, 0, 1), 1003);

        check("exp_q drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-port scheduler and scoreboard for the 32-entry, single-write-port CPU register file. It merges two writeback sources onto the one write port:

- the in-order pipeline writeback (ALU/load), which is never stalled;
- the long-latency unit (mul/div), which is buffered and written only on idle cycles.

A per-register busy scoreboard stalls issue on RAW/WAW hazards against outstanding long-latency destinations. It sits between the pipeline's WB stage, the long-latency unit and the register file's write port.

## Interface
- DATA_W, 64, write-data width
- MAX_OUT, 4, maximum outstanding long-latency ops (counter width $clog2(MAX_OUT+1))
- STARVE_MAX, 8, consecutive blocked cycles before issue is throttled
- i_clk  in  1  clock
- i_rst_n  in  1  reset: i_rst_n, asynchronous, active-low; clock i_clk
- i_issue_valid  in  1  instruction in issue stage
- i_issue_long  in  1  issuing instruction's rd is written by long-latency unit
- i_issue_rd / i_issue_rs1 / i_issue_rs2  in  5 each  destination / sources
- o_issue_stall  out  1  hold issue stage this cycle
- i_wb_valid  in  1  pipeline writeback request
- i_wb_rd  in  5  pipeline writeback register
- i_wb_data  in  DATA_W  pipeline writeback data
- i_lu_valid  in  1  long-unit result valid
- i_lu_rd  in  5  long-unit destination
- i_lu_data  in  DATA_W  long-unit result
- o_lu_ready  out  1  long-unit result accepted when valid&ready
- o_RegWrite  out  1  register file write enable
- o_WriteReg  out  5  register file write address
- o_WriteData  out  DATA_W  register file write data

## Operation
- State:
  - busy[31:1] scoreboard; bit 0 is never set
  - out_cnt, outstanding long ops
  - 1-entry hold register (hold_valid, hold_rd, hold_data)
  - starve_cnt
- Write-port priority:
  - pipeline WB first;
  - hold register otherwise;
  - else idle.
  - Output mux is combinational.
- Pipeline WB with i_wb_rd==0: o_RegWrite=0. This is required because the register file forwards write data combinationally to its read ports.
- Hold with hold_rd==0: drains without asserting o_RegWrite.
- Long-unit capture:
  - o_lu_ready = ~hold_valid.
  - On valid&ready, capture into the hold register. No direct path to the port; minimum 1-cycle latency.
- Drain: hold_valid & ~i_wb_valid → port written from hold; hold_valid cleared next edge; busy[hold_rd] cleared; out_cnt decremented.
- Long issue fire (issue_valid & long & ~stall):
  - out_cnt increments;
  - busy[rd] set if rd≠0.
- Simultaneous issue-fire and drain: out_cnt unchanged. If the same rd is cleared and set in one cycle, the set wins.
- o_issue_stall = issue_valid & (hz1 | hz2 | hzd | full | starve):
  - hz1/hz2/hzd: busy of rs1/rs2/rd, excluding the register draining this cycle (the register file bypasses same-cycle write data);
  - full: long & out_cnt==MAX_OUT & ~drain;
  - starve: starve_cnt==STARVE_MAX.
- starve_cnt:
  - increments (saturating) each cycle hold_valid & i_wb_valid;
  - cleared on drain or when hold empty.
  - Saturated value forces issue stall so bubbles reach WB.
- Long unit returning an rd that is not busy is a protocol error. It is still written; out_cnt saturates at 0.

## Timing
- Reset (async assert, sync-safe deassert):
  - busy=0, out_cnt=0, hold_valid=0, starve_cnt=0.
  - While i_rst_n low: o_RegWrite=0, o_WriteReg=0, o_WriteData=0, o_lu_ready=0, o_issue_stall=1.
  - A reset mid-operation discards any held result.
- Pipeline WB to port: 0 cycles.
- Long result to port: ≥1 cycle after acceptance.
- Busy clear is visible to o_issue_stall in the drain cycle itself.
- Back-to-back long results: one per cycle max, only when WB idle.

## Structure
- Shared package regfile_pkg: NUM_REG=32, REG_IDX_W=5, default DATA_W.
- Sub-module regfile_scoreboard holds busy vector, out_cnt and the hazard/full compare. Inputs: set/clear ports and rs1/rs2/rd.
- Top holds the hold register, port mux and starve counter.

## Test plan
- Reset asserted mid-drain (hold_valid=1): next cycle o_RegWrite=0, o_lu_ready=0, o_issue_stall=1. After release: busy=0, o_lu_ready=1.
- Long issue rd=5, then ALU issue rs1=5 → stall each cycle until hold drains x5=0x1234. Stall drops in the drain cycle; the read sees 0x1234.
- i_wb_valid and hold both pending (wb rd=6=0xAA, hold rd=7=0xBB) → x6 written first, x7 the next idle cycle; o_lu_ready=0 meanwhile.
- Four long issues outstanding → fifth long issue stalls. A drain in the same cycle releases it; out_cnt stays 4.
- i_wb_valid held high 8 cycles with hold pending → o_issue_stall forced after cycle 8. Drain at first WB bubble; starve_cnt returns to 0.
- Pipeline WB rd=0 data 0xFF → o_RegWrite=0. Long issue rd=0 → no busy bit set; subsequent rs1=0 is not stalled.
